// File: rtl/rank_sort_stream_if.sv
// Valid/ready stream bundle for the rank sorter: key input stream and sorted output stream.
interface rank_sort_stream_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/rank_sort_stream.sv
// Streaming stable rank sorter: loads a frame of up to N keys, ranks one key per cycle,
// then emits keys in sorted order together with their arrival indices.
module rank_sort_stream #(
  parameter int unsigned N     = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = $clog2(N),
  parameter int unsigned CNTW  = $clog2(N + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_descend,
  output logic busy,
  rank_sort_stream_if.slave s
);

  typedef enum logic [1:0] {LOAD, RANK, EMIT} state_t;

  state_t           state, state_n;
  logic [CNTW-1:0]  count, count_n;
  logic [IDXW-1:0]  r, r_n;
  logic [IDXW-1:0]  ptr, ptr_n;
  logic [IDXW-1:0]  rank_c;
  logic             mode, mode_n;
  logic             in_ready_n, out_valid_n, out_last_n, busy_n;
  logic [WIDTH-1:0] out_data_n;
  logic [IDXW-1:0]  out_idx_n;
  logic             key_we, sbuf_we;

  logic [WIDTH-1:0] key      [N];
  logic [WIDTH-1:0] sbuf_key [N];
  logic [IDXW-1:0]  sbuf_idx [N];

  // Stable rank of key[r] among the current frame's entries only
  always_comb begin
    rank_c = '0;
    for (int j = 0; j < int'(N); j++) begin
      if (CNTW'(j) < count) begin
        if ((mode ? (key[j] > key[r]) : (key[j] < key[r])) ||
            ((key[j] == key[r]) && (IDXW'(j) < r)))
          rank_c = rank_c + IDXW'(1);
      end
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_n     = state;
    count_n     = count;
    r_n         = r;
    ptr_n       = ptr;
    mode_n      = mode;
    in_ready_n  = s.in_ready;
    out_valid_n = s.out_valid;
    out_data_n  = s.out_data;
    out_idx_n   = s.out_idx;
    out_last_n  = s.out_last;
    key_we      = 1'b0;
    sbuf_we     = 1'b0;

    case (state)
      LOAD: begin
        in_ready_n = 1'b1;
        if (s.in_valid && s.in_ready) begin
          key_we  = 1'b1;
          count_n = count + CNTW'(1);
          if (count == '0)
            mode_n = cfg_descend;
          if (s.in_last || (count == CNTW'(N - 1))) begin
            in_ready_n = 1'b0;
            state_n    = RANK;
            r_n        = '0;
          end
        end
      end
      RANK: begin
        sbuf_we = 1'b1;
        if (CNTW'(r) == count - CNTW'(1)) begin
          state_n     = EMIT;
          ptr_n       = '0;
          out_valid_n = 1'b1;
          out_last_n  = (count == CNTW'(1));
          // slot 0 may be the one being written on this very edge
          if (rank_c == '0) begin
            out_data_n = key[r];
            out_idx_n  = r;
          end else begin
            out_data_n = sbuf_key[0];
            out_idx_n  = sbuf_idx[0];
          end
        end else begin
          r_n = r + IDXW'(1);
        end
      end
      EMIT: begin
        if (s.out_ready) begin
          if (CNTW'(ptr) == count - CNTW'(1)) begin
            state_n     = LOAD;
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
            count_n     = '0;
            in_ready_n  = 1'b1;
          end else begin
            ptr_n      = ptr + IDXW'(1);
            out_data_n = sbuf_key[ptr + IDXW'(1)];
            out_idx_n  = sbuf_idx[ptr + IDXW'(1)];
            out_last_n = ((CNTW'(ptr) + CNTW'(2)) == count);
          end
        end
      end
      default: state_n = LOAD;
    endcase

    busy_n = (state_n != LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      count       <= '0;
      r           <= '0;
      ptr         <= '0;
      mode        <= 1'b0;
      busy        <= 1'b0;
      s.in_ready  <= 1'b0;
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.out_idx   <= '0;
      s.out_last  <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      r           <= r_n;
      ptr         <= ptr_n;
      mode        <= mode_n;
      busy        <= busy_n;
      s.in_ready  <= in_ready_n;
      s.out_valid <= out_valid_n;
      s.out_data  <= out_data_n;
      s.out_idx   <= out_idx_n;
      s.out_last  <= out_last_n;
    end
  end

  // Key and sorted-buffer storage; contents are only meaningful within a frame
  always_ff @(posedge clk) begin
    if (key_we)
      key[IDXW'(count)] <= s.in_data;
    if (sbuf_we) begin
      sbuf_key[rank_c] <= key[r];
      sbuf_idx[rank_c] <= r;
    end
  end

endmodule
